mmu_param: RTL and testbench
============================

MMU_PARAM -- requirements
Module: mmu_param

Interface
REQ-001 SHALL have parameter TLB_NR_ENTRY, default 16: number of TLB entries, power of two, 2..64.
REQ-002 SHALL have parameter PAGE_BITS, default 12: page-offset width, 12..16; VPN2 = addr[31:PAGE_BITS+1].
REQ-003 SHALL have parameter PA_BITS, default 32: physical address width, 29..32.
REQ-004 clk  input  1  single clock; all registers update on the falling edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 ce  input  1  data-port request (`ChipEnable); when low, the PC port owns the bus.
REQ-007 we_i  input  1  data write (`WriteEnable).
REQ-008 sel  input  4  byte lanes.
REQ-009 addr / data_i  input  32 / 32  data virtual address / write data, in lane position.
REQ-010 data_o, data_inst  output  32  both equal dev_mem_data_in.
REQ-011 addr_pc  input  32  instruction virtual address.
REQ-012 asid  input  8  current address-space identifier.
REQ-013 tlb_write_struct  input  `TLB_WRITE_STRUCT_WIDTH  {enable, index, entry}.
REQ-014 busy  output  1  state != IDLE or dev_mem_busy.
REQ-015 exc_code / exc_code_pc  output  `EXC_CODE_WIDTH  data / fetch exception, combinational.
REQ-016 dev_mem_addr  output  PA_BITS  registered physical address.
REQ-017 dev_mem_data_out / dev_mem_data_in  output / input  32  device write / read data.
REQ-018 dev_mem_is_write / dev_mem_busy  output / input  1  device write strobe / device stall.

Function
REQ-019 Translation: 0x8000_0000..0xBFFF_FFFF SHALL map directly, PA = {0, va[28:0]}; all other addresses go through the TLB.
REQ-020 Entry hit = VPN2 match, and V of the even page (va[PAGE_BITS]=0) or the odd page (=1); with multiple hits the lowest index SHALL win.
REQ-021 PA = {PFN of the hit page, va[PAGE_BITS-1:0]}, truncated to PA_BITS; D bit of the hit page = writable.
REQ-022 Legal sel: 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other code -> EC_ADEL (read) / EC_ADES (write).
REQ-023 Fetch: va[1:0]!=0 -> EC_ADEL; TLB miss -> EC_TLBL; exc_code_pc reported only while IDLE, !dev_mem_busy and ce low.
REQ-024 Data priority, highest first: miss (EC_TLBL / EC_TLBS) > write to non-writable page (EC_TLB_MOD) > illegal sel.
REQ-025 FSM states: IDLE, MERGE, WRITE.
REQ-026 IDLE SHALL accept a write when ce, !dev_mem_busy and exc_code==EC_NONE, latching data_i.
REQ-027 Accepted write with sel==1111 -> WRITE with dev_mem_is_write=1; any other legal sel -> MERGE with dev_mem_is_write=0.
REQ-028 MERGE SHALL replace the unselected lanes with dev_mem_data_in (read-modify-write), then go to WRITE with dev_mem_is_write=1.
REQ-029 WRITE SHALL hold one cycle, then return to IDLE with dev_mem_is_write=0.
REQ-030 Write latency: full-word write 2 cycles, partial write 3 cycles, from acceptance to return to IDLE.
REQ-031 Reads SHALL not leave IDLE; data_o is valid whenever busy is low.
REQ-032 dev_mem_addr SHALL register the translated data address when ce is high, else the fetch address, every cycle in which state==IDLE.
REQ-033 Requests raising an exception SHALL not change state or assert dev_mem_is_write.
REQ-034 A TLB write SHALL take effect on the falling edge; a lookup in the same cycle SHALL see the old contents.

Reset
REQ-035 rst low SHALL immediately set: state=IDLE, dev_mem_is_write=0, dev_mem_addr=0, dev_mem_data_out=0, all TLB entries=0 (all invalid).
REQ-036 Reset during MERGE or WRITE SHALL abort without a device write.

Configuration
REQ-037 With MMU_ASID_EN defined, a hit additionally requires entry ASID==asid or entry G=1.
REQ-038 Without MMU_ASID_EN, the asid input and entry ASID/G fields SHALL be ignored, giving global matching.

Structure
REQ-039 The shared header SHALL hold the TLB entry field offsets, `TLB_ENTRY_WIDTH, `TLB_WRITE_STRUCT_WIDTH, the EC_* codes and the FSM state encodings.
REQ-040 Lookup SHALL be a separate combinational sub-module, tlb_lookup, instantiated twice (data and fetch): hit, index, PA, writable.

Verification
REQ-041 Direct map: ce=1, we_i=0, addr=0x8000_1234 -> dev_mem_addr=0x0000_1234, exc_code=EC_NONE.
REQ-042 TLB hit: entry 3 with VPN2=0x00400>>1 and odd PFN=0x12, V=1, D=0; read 0x0040_1008 -> dev_mem_addr=0x0001_2008. Store to same address -> EC_TLB_MOD, no write.
REQ-043 Partial write: dev_mem_data_in=0xAABBCCDD, sel=0011, data_i=0x0000_1122 -> after MERGE, dev_mem_data_out=0xAABB1122 with dev_mem_is_write=1 for one cycle.
REQ-044 Exceptions: addr_pc=0x0000_0002 with ce=0 -> exc_code_pc=EC_ADEL; store with sel=0101 -> EC_ADES, state stays IDLE.
REQ-045 ASID (MMU_ASID_EN): entry ASID=5, G=0; asid=6 -> EC_TLBL; after setting G=1 -> hit.
REQ-046 Reset: rst low in MERGE -> state=IDLE, dev_mem_is_write=0, all lookups miss.

Source files
------------

// File: rtl/mmu_param_pkg.sv
// Shared definitions for mmu_param: TLB entry layout, write-port layout, exception codes, FSM encoding.
`ifndef MMU_PARAM_DEFS_SVH
`define MMU_PARAM_DEFS_SVH
`define TLB_ENTRY_WIDTH        72
`define TLB_WRITE_STRUCT_WIDTH 79
`define EXC_CODE_WIDTH         5
`endif

package mmu_param_pkg;

    localparam int TLB_ENTRY_W = `TLB_ENTRY_WIDTH;
    localparam int TLB_WR_W    = `TLB_WRITE_STRUCT_WIDTH;
    localparam int EXC_W       = `EXC_CODE_WIDTH;

    // Entry layout, MSB to LSB: {VPN2[18:0], ASID[7:0], G, PFN0[19:0], D0, V0, PFN1[19:0], D1, V1}
    localparam int E_V1   = 0;
    localparam int E_D1   = 1;
    localparam int E_PFN1 = 2;
    localparam int E_V0   = 22;
    localparam int E_D0   = 23;
    localparam int E_PFN0 = 24;
    localparam int E_G    = 44;
    localparam int E_ASID = 45;
    localparam int E_VPN2 = 53;
    localparam int PFN_W  = 20;
    localparam int ASID_W = 8;
    localparam int VPN2_W = 19;

    // Write port layout: {enable, index[5:0], entry}
    localparam int TW_ENTRY   = 0;
    localparam int TW_INDEX   = 72;
    localparam int TW_INDEX_W = 6;
    localparam int TW_EN      = 78;

    typedef enum logic [EXC_W-1:0] {
        EC_TLB_MOD = 5'd1,
        EC_TLBL    = 5'd2,
        EC_TLBS    = 5'd3,
        EC_ADEL    = 5'd4,
        EC_ADES    = 5'd5,
        EC_NONE    = 5'd31
    } exc_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_WRITE = 2'd2
    } mmu_state_t;

    function automatic logic sel_legal(input logic [3:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] wdata,
                                               input logic [31:0] rdata,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = sel[b] ? wdata[8*b +: 8] : rdata[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/mmu_param_tlb_lookup.sv
// Combinational TLB search: lowest matching index wins, returns PA and writable flag.
// MMU_ASID_EN adds the ASID/G qualification; otherwise matching is global.
module tlb_lookup
    import mmu_param_pkg::*;
#(
    parameter int TLB_NR_ENTRY = 16,
    parameter int PAGE_BITS    = 12,
    parameter int PA_BITS      = 32,
    parameter int IDX_W        = $clog2(TLB_NR_ENTRY)
)(
    input  logic [TLB_NR_ENTRY-1:0][TLB_ENTRY_W-1:0] i_entries,
    input  logic [31:0]                              i_va,
    input  logic [ASID_W-1:0]                        i_asid,
    output logic                                     o_hit,
    output logic [IDX_W-1:0]                         o_index,
    output logic [PA_BITS-1:0]                       o_pa,
    output logic                                     o_writable
);
    localparam int VPN2_USED = 31 - PAGE_BITS;

    logic [TLB_NR_ENTRY-1:0] w_match;
    logic [TLB_NR_ENTRY-1:0] w_asid_ok;
    logic [TLB_ENTRY_W-1:0]  w_ent;
    logic                    w_odd;
    logic [PFN_W-1:0]        w_pfn;
    logic                    w_unused_ok;

    assign w_odd       = i_va[PAGE_BITS];
    assign w_unused_ok = ^{i_entries, i_asid};

    for (genvar k = 0; k < TLB_NR_ENTRY; k++) begin : g_ent
`ifdef MMU_ASID_EN
        assign w_asid_ok[k] = i_entries[k][E_G] ||
                              (i_entries[k][E_ASID +: ASID_W] == i_asid);
`else
        assign w_asid_ok[k] = 1'b1;
`endif
        assign w_match[k] = (i_entries[k][E_VPN2 +: VPN2_USED] == i_va[31:PAGE_BITS+1]) &&
                            (w_odd ? i_entries[k][E_V1] : i_entries[k][E_V0]) &&
                            w_asid_ok[k];
    end

    // Descending scan so the last assignment is the lowest matching index.
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        w_ent   = '0;
        for (int k = TLB_NR_ENTRY - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_hit   = 1'b1;
                o_index = IDX_W'(k);
                w_ent   = i_entries[k];
            end
        end
    end

    assign w_pfn      = w_odd ? w_ent[E_PFN1 +: PFN_W] : w_ent[E_PFN0 +: PFN_W];
    assign o_writable = w_odd ? w_ent[E_D1] : w_ent[E_D0];
    assign o_pa       = PA_BITS'(({16'b0, w_pfn} << PAGE_BITS) | 36'(i_va[PAGE_BITS-1:0]));

endmodule

// File: rtl/mmu_param.sv
// MMU with shared data/fetch device port, direct-mapped kseg window, TLB translation and
// read-modify-write for partial stores. MMU_ASID_EN enables ASID-qualified TLB matching.
module mmu_param
    import mmu_param_pkg::*;
#(
    parameter int TLB_NR_ENTRY = 16,
    parameter int PAGE_BITS    = 12,
    parameter int PA_BITS      = 32
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ce,
    input  logic                               we_i,
    input  logic [3:0]                         sel,
    input  logic [31:0]                        addr,
    input  logic [31:0]                        data_i,
    output logic [31:0]                        data_o,
    output logic [31:0]                        data_inst,
    input  logic [31:0]                        addr_pc,
    input  logic [7:0]                         asid,
    input  logic [`TLB_WRITE_STRUCT_WIDTH-1:0] tlb_write_struct,
    output logic                               busy,
    output logic [`EXC_CODE_WIDTH-1:0]         exc_code,
    output logic [`EXC_CODE_WIDTH-1:0]         exc_code_pc,
    output logic [PA_BITS-1:0]                 dev_mem_addr,
    output logic [31:0]                        dev_mem_data_out,
    input  logic [31:0]                        dev_mem_data_in,
    output logic                               dev_mem_is_write,
    input  logic                               dev_mem_busy
);
    // state  | meaning
    // IDLE   | translate every cycle, accept stores, serve reads
    // MERGE  | partial store: fold device read data into unselected lanes
    // WRITE  | one-cycle device write strobe
    localparam int IDX_W = $clog2(TLB_NR_ENTRY);

    logic [TLB_NR_ENTRY-1:0][TLB_ENTRY_W-1:0] r_tlb;
    mmu_state_t          r_state, w_state_nxt;
    logic                r_is_write, w_is_write_nxt;
    logic [PA_BITS-1:0]  r_addr, w_addr_nxt;
    logic [31:0]         r_dout, w_dout_nxt;
    logic [3:0]          r_sel, w_sel_nxt;

    logic                w_d_lk_hit, w_d_lk_wr, w_pc_lk_hit, w_pc_wr;
    logic [IDX_W-1:0]    w_d_idx, w_pc_idx;
    logic [PA_BITS-1:0]  w_d_lk_pa, w_pc_lk_pa;
    logic                w_d_direct, w_pc_direct;
    logic                w_d_hit, w_d_wr, w_pc_hit;
    logic [PA_BITS-1:0]  w_d_pa, w_pc_pa;
    exc_code_t           w_exc, w_exc_pc;
    logic [IDX_W-1:0]    w_tlb_idx;
    logic                w_unused_top;

    tlb_lookup #(.TLB_NR_ENTRY(TLB_NR_ENTRY), .PAGE_BITS(PAGE_BITS), .PA_BITS(PA_BITS)) u_lk_data (
        .i_entries(r_tlb), .i_va(addr), .i_asid(asid),
        .o_hit(w_d_lk_hit), .o_index(w_d_idx), .o_pa(w_d_lk_pa), .o_writable(w_d_lk_wr)
    );

    tlb_lookup #(.TLB_NR_ENTRY(TLB_NR_ENTRY), .PAGE_BITS(PAGE_BITS), .PA_BITS(PA_BITS)) u_lk_fetch (
        .i_entries(r_tlb), .i_va(addr_pc), .i_asid(asid),
        .o_hit(w_pc_lk_hit), .o_index(w_pc_idx), .o_pa(w_pc_lk_pa), .o_writable(w_pc_wr)
    );

    // 0x8000_0000..0xBFFF_FFFF bypasses the TLB and is always writable.
    assign w_d_direct  = (addr[31:30] == 2'b10);
    assign w_pc_direct = (addr_pc[31:30] == 2'b10);
    assign w_d_hit     = w_d_direct | w_d_lk_hit;
    assign w_d_wr      = w_d_direct | w_d_lk_wr;
    assign w_d_pa      = w_d_direct ? PA_BITS'({3'b0, addr[28:0]}) : w_d_lk_pa;
    assign w_pc_hit    = w_pc_direct | w_pc_lk_hit;
    assign w_pc_pa     = w_pc_direct ? PA_BITS'({3'b0, addr_pc[28:0]}) : w_pc_lk_pa;

    always_comb begin
        w_exc = EC_NONE;
        if (ce) begin
            if (we_i) begin
                if (!w_d_hit)             w_exc = EC_TLBS;
                else if (!w_d_wr)         w_exc = EC_TLB_MOD;
                else if (!sel_legal(sel)) w_exc = EC_ADES;
            end else begin
                if (!w_d_hit)             w_exc = EC_TLBL;
                else if (!sel_legal(sel)) w_exc = EC_ADEL;
            end
        end
    end

    always_comb begin
        w_exc_pc = EC_NONE;
        if ((r_state == ST_IDLE) && !dev_mem_busy && !ce) begin
            if (addr_pc[1:0] != 2'b00) w_exc_pc = EC_ADEL;
            else if (!w_pc_hit)        w_exc_pc = EC_TLBL;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_is_write_nxt = r_is_write;
        w_addr_nxt     = r_addr;
        w_dout_nxt     = r_dout;
        w_sel_nxt      = r_sel;
        unique case (r_state)
            ST_IDLE: begin
                w_is_write_nxt = 1'b0;
                w_addr_nxt     = ce ? w_d_pa : w_pc_pa;
                if (ce && we_i && !dev_mem_busy && (w_exc == EC_NONE)) begin
                    w_dout_nxt = data_i;
                    w_sel_nxt  = sel;
                    if (sel == 4'b1111) begin
                        w_is_write_nxt = 1'b1;
                        w_state_nxt    = ST_WRITE;
                    end else begin
                        w_state_nxt    = ST_MERGE;
                    end
                end
            end
            ST_MERGE: begin
                w_dout_nxt     = lane_merge(r_dout, dev_mem_data_in, r_sel);
                w_is_write_nxt = 1'b1;
                w_state_nxt    = ST_WRITE;
            end
            ST_WRITE: begin
                w_is_write_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_is_write_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_sel      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_is_write <= w_is_write_nxt;
            r_addr     <= w_addr_nxt;
            r_dout     <= w_dout_nxt;
            r_sel      <= w_sel_nxt;
        end
    end

    assign w_tlb_idx = tlb_write_struct[TW_INDEX +: IDX_W];

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_tlb <= '0;
        end else if (tlb_write_struct[TW_EN]) begin
            r_tlb[w_tlb_idx] <= tlb_write_struct[TW_ENTRY +: TLB_ENTRY_W];
        end
    end

    assign w_unused_top     = ^{w_d_idx, w_pc_idx, w_pc_wr, tlb_write_struct};
    assign busy             = (r_state != ST_IDLE) || dev_mem_busy;
    assign exc_code         = w_exc;
    assign exc_code_pc      = w_exc_pc;
    assign dev_mem_addr     = r_addr;
    assign dev_mem_data_out = r_dout;
    assign dev_mem_is_write = r_is_write;
    assign data_o           = dev_mem_data_in;
    assign data_inst        = dev_mem_data_in;

endmodule

// File: tb/tb_mmu_param.sv
// Directed bench for mmu_param: vector table for translation/exceptions plus hand sequences.
module tb_mmu_param;
    import mmu_param_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce, we_i, dev_mem_busy, dev_mem_is_write, busy;
    logic [3:0]         sel;
    logic [31:0]        addr, data_i, data_o, data_inst, addr_pc;
    logic [31:0]        dev_mem_data_out, dev_mem_data_in, dev_mem_addr;
    logic [7:0]         asid;
    logic [TLB_WR_W-1:0] tlb_write_struct;
    logic [EXC_W-1:0]   exc_code, exc_code_pc;

    int checks = 0;
    int failures = 0;

    mmu_param dut (
        .clk(clk), .rst(rst), .ce(ce), .we_i(we_i), .sel(sel), .addr(addr),
        .data_i(data_i), .data_o(data_o), .data_inst(data_inst), .addr_pc(addr_pc),
        .asid(asid), .tlb_write_struct(tlb_write_struct), .busy(busy),
        .exc_code(exc_code), .exc_code_pc(exc_code_pc), .dev_mem_addr(dev_mem_addr),
        .dev_mem_data_out(dev_mem_data_out), .dev_mem_data_in(dev_mem_data_in),
        .dev_mem_is_write(dev_mem_is_write), .dev_mem_busy(dev_mem_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ce;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [4:0]  exp_exc;
        logic [4:0]  exp_pc;
        logic        chk_addr;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [TLB_ENTRY_W-1:0] mk_entry(
        input logic [18:0] vpn2, input logic [7:0] easid, input logic g,
        input logic [19:0] pfn0, input logic d0, input logic v0,
        input logic [19:0] pfn1, input logic d1, input logic v1);
        logic [TLB_ENTRY_W-1:0] e;
        e = '0;
        e[E_VPN2 +: VPN2_W] = vpn2;
        e[E_ASID +: ASID_W] = easid;
        e[E_G]              = g;
        e[E_PFN0 +: PFN_W]  = pfn0;
        e[E_D0]             = d0;
        e[E_V0]             = v0;
        e[E_PFN1 +: PFN_W]  = pfn1;
        e[E_D1]             = d1;
        e[E_V1]             = v1;
        return e;
    endfunction

    function automatic vec_t mkv(input string nm, input logic vce, input logic vwe,
        input logic [3:0] vsel, input logic [31:0] va, input logic [31:0] vpc,
        input logic [4:0] ee, input logic [4:0] ep, input logic ca, input logic [31:0] ea);
        vec_t v;
        v.name = nm; v.ce = vce; v.we = vwe; v.sel = vsel; v.addr = va; v.pc = vpc;
        v.exp_exc = ee; v.exp_pc = ep; v.chk_addr = ca; v.exp_addr = ea;
        return v;
    endfunction

    // All tasks start and end just after a rising edge; the DUT updates on falling edges.
    task automatic tlb_wr(input int idx, input logic [TLB_ENTRY_W-1:0] e);
        tlb_write_struct = {1'b1, TW_INDEX_W'(idx), e};
        @(posedge clk); #1;
        tlb_write_struct = '0;
    endtask

    task automatic idle_inputs();
        ce = 1'b0; we_i = 1'b0; sel = 4'hF; addr = 32'h0; data_i = 32'h0;
        addr_pc = 32'h8000_0000;
    endtask

    initial begin
        rst = 1'b0; dev_mem_busy = 1'b0; dev_mem_data_in = 32'h0; asid = 8'd0;
        tlb_write_struct = '0;
        idle_inputs();
        #1;
        chk("rst_is_write", 32'(dev_mem_is_write), 0);
        chk("rst_addr", dev_mem_addr, 0);
        chk("rst_dout", dev_mem_data_out, 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        tlb_wr(3, mk_entry(19'h200, 8'd0, 1'b0, 20'h0, 1'b0, 1'b0, 20'h12, 1'b0, 1'b1));
        tlb_wr(5, mk_entry(19'h201, 8'd0, 1'b0, 20'h34, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0));
        tlb_wr(7, mk_entry(19'h200, 8'd0, 1'b0, 20'h0, 1'b0, 1'b0, 20'h99, 1'b1, 1'b1));

        vecs.push_back(mkv("direct_rd",   1, 0, 4'hF, 32'h8000_1234, 32'h0, EC_NONE, EC_NONE, 1, 32'h0000_1234));
        vecs.push_back(mkv("direct_top",  1, 0, 4'hF, 32'hBFFF_FFFC, 32'h0, EC_NONE, EC_NONE, 1, 32'h1FFF_FFFC));
        vecs.push_back(mkv("above_win",   1, 0, 4'hF, 32'hC000_0000, 32'h0, EC_TLBL, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("below_win",   1, 0, 4'hF, 32'h7FFF_FFFC, 32'h0, EC_TLBL, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("tlb_hit_odd", 1, 0, 4'hF, 32'h0040_1008, 32'h0, EC_NONE, EC_NONE, 1, 32'h0001_2008));
        vecs.push_back(mkv("st_ro_page",  1, 1, 4'hF, 32'h0040_1008, 32'h0, EC_TLB_MOD, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("even_inval",  1, 0, 4'hF, 32'h0040_0008, 32'h0, EC_TLBL, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("st_miss",     1, 1, 4'hF, 32'h0040_0008, 32'h0, EC_TLBS, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("tlb_hit_even",1, 0, 4'h1, 32'h0040_2ABC, 32'h0, EC_NONE, EC_NONE, 1, 32'h0003_4ABC));
        vecs.push_back(mkv("rd_bad_sel",  1, 0, 4'h5, 32'h8000_0000, 32'h0, EC_ADEL, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("st_bad_sel",  1, 1, 4'h5, 32'h8000_0000, 32'h0, EC_ADES, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("mod_over_sel",1, 1, 4'h6, 32'h0040_1008, 32'h0, EC_TLB_MOD, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("miss_over_sel",1,1, 4'h5, 32'h0040_0008, 32'h0, EC_TLBS, EC_NONE, 0, 32'h0));
        vecs.push_back(mkv("pc_unalign",  0, 0, 4'hF, 32'h0, 32'h0000_0002, EC_NONE, EC_ADEL, 0, 32'h0));
        vecs.push_back(mkv("pc_direct",   0, 0, 4'hF, 32'h0, 32'h8000_0100, EC_NONE, EC_NONE, 1, 32'h0000_0100));
        vecs.push_back(mkv("pc_tlb_hit",  0, 1, 4'hF, 32'h0, 32'h0040_2010, EC_NONE, EC_NONE, 1, 32'h0003_4010));
        vecs.push_back(mkv("pc_miss",     0, 0, 4'hF, 32'h0, 32'h0000_0000, EC_NONE, EC_TLBL, 0, 32'h0));
        vecs.push_back(mkv("pc_gated_ce", 1, 0, 4'hF, 32'h8000_0010, 32'h0000_0002, EC_NONE, EC_NONE, 1, 32'h0000_0010));

        foreach (vecs[i]) begin
            ce = vecs[i].ce; we_i = vecs[i].we; sel = vecs[i].sel; addr = vecs[i].addr;
            addr_pc = vecs[i].pc; data_i = 32'h1234_5678;
            dev_mem_data_in = 32'h5A5A_0000 + 32'(i);
            @(posedge clk);
            chk({vecs[i].name, "_exc"}, 32'(exc_code), 32'(vecs[i].exp_exc));
            chk({vecs[i].name, "_exc_pc"}, 32'(exc_code_pc), 32'(vecs[i].exp_pc));
            if (vecs[i].chk_addr) chk({vecs[i].name, "_addr"}, dev_mem_addr, vecs[i].exp_addr);
            chk({vecs[i].name, "_is_write"}, 32'(dev_mem_is_write), 0);
            chk({vecs[i].name, "_busy"}, 32'(busy), 0);
            chk({vecs[i].name, "_data_o"}, data_o, 32'h5A5A_0000 + 32'(i));
            chk({vecs[i].name, "_data_inst"}, data_inst, 32'h5A5A_0000 + 32'(i));
            #1;
        end
        idle_inputs();

        // TLB write and lookup in the same cycle: lookup sees the old (empty) slot.
        ce = 1'b1; sel = 4'hF; addr = 32'h0040_4000;
        tlb_write_struct = {1'b1, 6'd9, mk_entry(19'h202, 8'd0, 1'b0, 20'h56, 1'b1, 1'b1, 20'h0, 1'b0, 1'b0)};
        #2;
        chk("tlbw_old_view", 32'(exc_code), 32'(EC_TLBL));
        @(posedge clk);
        chk("tlbw_new_view", 32'(exc_code), 32'(EC_NONE));
        #1;
        tlb_write_struct = '0;
        @(posedge clk);
        chk("tlbw_new_addr", dev_mem_addr, 32'h0005_6000);
        #1;

        // ASID: entry ASID=5, G=0, request asid=6; then G=1.
        tlb_wr(10, mk_entry(19'h300, 8'd5, 1'b0, 20'h0, 1'b0, 1'b0, 20'h77, 1'b1, 1'b1));
        asid = 8'd6; addr = 32'h0060_1000;
        @(posedge clk);
`ifdef MMU_ASID_EN
        chk("asid_mismatch", 32'(exc_code), 32'(EC_TLBL));
`else
        chk("asid_ignored", 32'(exc_code), 32'(EC_NONE));
`endif
        #1;
        tlb_wr(10, mk_entry(19'h300, 8'd5, 1'b1, 20'h0, 1'b0, 1'b0, 20'h77, 1'b1, 1'b1));
        @(posedge clk);
        chk("asid_global", 32'(exc_code), 32'(EC_NONE));
        chk("asid_global_addr", dev_mem_addr, 32'h0007_7000);
        #1;
        asid = 8'd0;
        idle_inputs();

        // Full-word store: IDLE -> WRITE -> IDLE.
        ce = 1'b1; we_i = 1'b1; sel = 4'hF; addr = 32'h8000_0040; data_i = 32'hDEAD_BEEF;
        @(posedge clk);
        chk("full_is_write", 32'(dev_mem_is_write), 1);
        chk("full_busy", 32'(busy), 1);
        chk("full_dout", dev_mem_data_out, 32'hDEAD_BEEF);
        chk("full_addr", dev_mem_addr, 32'h0000_0040);
        #1; idle_inputs();
        @(posedge clk);
        chk("full_done_is_write", 32'(dev_mem_is_write), 0);
        chk("full_done_busy", 32'(busy), 0);
        #1;

        // Partial store: IDLE -> MERGE -> WRITE -> IDLE.
        dev_mem_data_in = 32'hAABB_CCDD;
        ce = 1'b1; we_i = 1'b1; sel = 4'b0011; addr = 32'h8000_0080; data_i = 32'h0000_1122;
        @(posedge clk);
        chk("part_merge_is_write", 32'(dev_mem_is_write), 0);
        chk("part_merge_busy", 32'(busy), 1);
        #1; idle_inputs();
        @(posedge clk);
        chk("part_write_is_write", 32'(dev_mem_is_write), 1);
        chk("part_write_dout", dev_mem_data_out, 32'hAABB_1122);
        chk("part_write_addr", dev_mem_addr, 32'h0000_0080);
        #1;
        @(posedge clk);
        chk("part_done_is_write", 32'(dev_mem_is_write), 0);
        chk("part_done_busy", 32'(busy), 0);
        #1;

        // Partial store to a writable TLB page, upper half.
        dev_mem_data_in = 32'h1111_2222;
        ce = 1'b1; we_i = 1'b1; sel = 4'b1100; addr = 32'h0040_2000; data_i = 32'h3344_0000;
        @(posedge clk); #1; idle_inputs();
        @(posedge clk);
        chk("part_tlb_dout", dev_mem_data_out, 32'h3344_2222);
        chk("part_tlb_addr", dev_mem_addr, 32'h0003_4000);
        #1;
        @(posedge clk); #1;

        // Device stall blocks acceptance and masks the fetch exception.
        dev_mem_busy = 1'b1;
        ce = 1'b1; we_i = 1'b1; sel = 4'hF; addr = 32'h8000_0000;
        @(posedge clk);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_no_write", 32'(dev_mem_is_write), 0);
        #1; idle_inputs(); addr_pc = 32'h0000_0002;
        #1;
        chk("stall_pc_masked", 32'(exc_code_pc), 32'(EC_NONE));
        dev_mem_busy = 1'b0;
        @(posedge clk);
        chk("stall_release_busy", 32'(busy), 0);
        chk("stall_release_no_write", 32'(dev_mem_is_write), 0);
        #1; idle_inputs();

        // Reset while in MERGE aborts the store and clears the TLB.
        ce = 1'b1; we_i = 1'b1; sel = 4'b0001; addr = 32'h8000_0100; data_i = 32'h0000_00EE;
        @(posedge clk);
        chk("rstm_in_merge", 32'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("rstm_busy", 32'(busy), 0);
        chk("rstm_is_write", 32'(dev_mem_is_write), 0);
        chk("rstm_addr", dev_mem_addr, 32'h0);
        chk("rstm_dout", dev_mem_data_out, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        ce = 1'b1; addr = 32'h0040_1008;
        @(posedge clk);
        chk("rstm_tlb_cleared", 32'(exc_code), 32'(EC_TLBL));
        chk("rstm_no_write", 32'(dev_mem_is_write), 0);
        #1;
        addr = 32'h0040_2ABC;
        @(posedge clk);
        chk("rstm_tlb_cleared2", 32'(exc_code), 32'(EC_TLBL));
        chk("rstm_idle", 32'(busy), 0);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
